input_port_buffer: RTL and testbench
====================================

INPUT_PORT_BUFFER -- requirements
Module: input_port_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 8; FIFO depth in flits, power of two, minimum 2.
REQ-002 SHALL have parameter DATA_W, default 32; flit payload width.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port wr_en, input, 1: the link writes one flit this cycle.
REQ-006 SHALL have port flit_id_in, input, 3: flit type of the incoming flit.
REQ-007 SHALL have port data_in, input, DATA_W: incoming flit payload.
REQ-008 SHALL have port grant, input, 1: the arbiter one-hot state bit for this port.
REQ-009 SHALL have port full, output, 1: FIFO holds DEPTH flits.
REQ-010 SHALL have port empty, output, 1: FIFO holds no flits.
REQ-011 SHALL have port req, output, 1: request to the arbiter.
REQ-012 SHALL have port flit_id_out, output, 3: type of the last popped flit (feeds the arbiter flit_id).
REQ-013 SHALL have port data_out, output, DATA_W: payload of the last popped flit.
REQ-014 SHALL have port length_out, output, 12: length of the current packet (feeds the arbiter length).
REQ-015 SHALL have port valid_out, output, 1: one-cycle pulse marking that data_out and flit_id_out are new.
REQ-016 SHALL have port drop, output, 1: one-cycle pulse when a malformed flit is discarded.

Function
REQ-017 Flit types SHALL be encoded HEADER=3'b001, BODY=3'b010, TAIL=3'b100; any other code SHALL be treated as malformed.
REQ-018 The FIFO SHALL store {flit_id, data} per entry and keep an occupancy count of width log2(DEPTH)+1.
REQ-019 A write SHALL occur iff wr_en && !full, where full is the pre-edge value; a write while full SHALL be ignored, even if a pop occurs in the same cycle.
REQ-020 Pointers SHALL wrap modulo DEPTH.
REQ-021 full SHALL equal (count==DEPTH) and empty SHALL equal (count==0); both SHALL be registered-state derived with no input combinational path.
REQ-022 The packet FSM SHALL have two states, IDLE and IN_PKT.
REQ-023 In IDLE, req SHALL equal (!empty && head type==HEADER); in IN_PKT, req SHALL be 1, holding the grant during body gaps (wormhole).
REQ-024 A pop SHALL occur iff grant && !empty && (state==IN_PKT || head==HEADER).
REQ-025 A pop SHALL update data_out and flit_id_out at the next edge and pulse valid_out; otherwise these outputs SHALL hold and valid_out SHALL be 0.
REQ-026 Popping a HEADER SHALL move the FSM to IN_PKT and load length_out with head data[11:0] at the same edge.
REQ-027 Popping a TAIL SHALL return the FSM to IDLE.
REQ-028 Popping a BODY SHALL leave the FSM state unchanged.
REQ-029 In IDLE, a non-HEADER head SHALL be discarded (count decremented) without grant, and drop SHALL pulse that cycle.
REQ-030 In IN_PKT, a HEADER or malformed code at the head SHALL be discarded with a drop pulse, and the FSM SHALL stay in IN_PKT.
REQ-031 A simultaneous write and pop SHALL leave count unchanged.
REQ-032 A write into an empty FIFO SHALL be poppable no earlier than the following cycle.
REQ-033 Latency from write to data_out SHALL be at least 2 cycles.

Reset
REQ-034 While rst=1 at an edge, pointers and count SHALL clear to 0, the FSM SHALL enter IDLE, and data_out, flit_id_out, length_out, valid_out and drop SHALL clear to 0.
REQ-035 While rst=1 at an edge, empty SHALL read 1 and full and req SHALL read 0.
REQ-036 A reset mid-packet SHALL discard all stored flits; rst SHALL take priority over wr_en and grant.

Structure
REQ-037 A shared package SHALL hold the flit-type constants, the 12-bit LENGTH_W and the default DATA_W.
REQ-038 Storage and pointers SHALL live in one sub-module, flit_fifo; the FSM, pop logic and output registers SHALL live in input_port_buffer.

Verification
REQ-039 Write HDR(len=5), BODY, TAIL with grant=1 -> req=1 on the cycle after the HDR write, three valid_out pulses, length_out=5, FSM back in IDLE, req=0.
REQ-040 Nine writes with DEPTH=8 and no grant -> full=1 after 8 writes, 9th flit lost, count=8.
REQ-041 HDR popped, FIFO empty for 3 cycles, then BODY and TAIL written -> req stays 1 throughout; BODY and TAIL popped in order.
REQ-042 BODY written while IDLE -> drop pulses once, valid_out=0, empty=1 afterwards.
REQ-043 Full FIFO with grant=1 and wr_en=1 in the same cycle -> one pop, write rejected, count=7.
REQ-044 rst asserted after the HDR pop, mid-packet -> next cycle empty=1, req=0, length_out=0, FSM in IDLE.

Source files
------------

// File: rtl/input_port_buffer_pkg.sv
// ---------------------------------------------------------------------------
// input_port_buffer_pkg
// Shared definitions for the router input-port buffer: flit-type codes,
// the packet length width, the default payload width and the packet FSM
// state type.
// ---------------------------------------------------------------------------
package input_port_buffer_pkg;

   localparam int LENGTH_W       = 12;
   localparam int DATA_W_DEFAULT = 32;
   localparam int FLIT_ID_W      = 3;

   localparam logic [FLIT_ID_W-1:0] FLIT_HEADER = 3'b001;
   localparam logic [FLIT_ID_W-1:0] FLIT_BODY   = 3'b010;
   localparam logic [FLIT_ID_W-1:0] FLIT_TAIL   = 3'b100;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      IN_PKT = 1'b1
   } pkt_state_e;

   // BODY and TAIL are the only codes that may follow a HEADER inside a packet.
   function automatic logic is_payload_flit(input logic [FLIT_ID_W-1:0] id);
      return (id == FLIT_BODY) || (id == FLIT_TAIL);
   endfunction

endpackage

// File: rtl/flit_fifo.sv
// ---------------------------------------------------------------------------
// flit_fifo
// Circular buffer of {flit_id, data} entries with an occupancy counter.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   wr_en, wr_id,     write request and flit; ignored while full, even when
//   wr_data           a read happens in the same cycle
//   rd_en             remove the head entry (ignored while empty)
//   head_id,head_data entry currently at the head of the queue
//   full, empty       occupancy flags, derived from the registered count only
// ---------------------------------------------------------------------------
module flit_fifo
   import input_port_buffer_pkg::*;
#(
   parameter int DEPTH  = 8,
   parameter int DATA_W = DATA_W_DEFAULT
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wr_en,
   input  logic [FLIT_ID_W-1:0] wr_id,
   input  logic [DATA_W-1:0]    wr_data,
   input  logic                 rd_en,
   output logic [FLIT_ID_W-1:0] head_id,
   output logic [DATA_W-1:0]    head_data,
   output logic                 full,
   output logic                 empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [FLIT_ID_W+DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]            count_q, count_d;
   logic                        wr_fire;
   logic                        rd_fire;

   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == {CNT_W{1'b0}});
   assign {head_id, head_data} = mem_q[rd_ptr_q];

   // Next pointers and count; DEPTH is a power of two so pointers wrap naturally.
   always_comb begin
      wr_fire  = wr_en && !full;
      rd_fire  = rd_en && !empty;
      wr_ptr_d = wr_fire ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
      rd_ptr_d = rd_fire ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
      case ({wr_fire, rd_fire})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= {PTR_W{1'b0}};
         rd_ptr_q <= {PTR_W{1'b0}};
         count_q  <= {CNT_W{1'b0}};
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage; contents need no reset because count gates visibility.
   always_ff @(posedge clk) begin
      if (wr_fire) begin
         mem_q[wr_ptr_q] <= {wr_id, wr_data};
      end
   end

endmodule

// File: rtl/input_port_buffer.sv
// ---------------------------------------------------------------------------
// input_port_buffer
// Router input port: buffers incoming flits, requests the arbiter for whole
// packets (wormhole: the request is held from HEADER pop to TAIL pop) and
// discards flits that cannot legally appear at the head.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   wr_en, flit_id_in,       one flit from the link per cycle
//   data_in
//   grant                    arbiter grant for this port
//   full, empty              FIFO occupancy flags
//   req                      request to the arbiter
//   flit_id_out, data_out    last popped flit (registered)
//   length_out               length field of the current packet's HEADER
//   valid_out                one-cycle pulse when data_out/flit_id_out change
//   drop                     one-cycle pulse after a malformed flit is discarded
// ---------------------------------------------------------------------------
module input_port_buffer
   import input_port_buffer_pkg::*;
#(
   parameter int DEPTH  = 8,
   parameter int DATA_W = DATA_W_DEFAULT
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wr_en,
   input  logic [FLIT_ID_W-1:0] flit_id_in,
   input  logic [DATA_W-1:0]    data_in,
   input  logic                 grant,
   output logic                 full,
   output logic                 empty,
   output logic                 req,
   output logic [FLIT_ID_W-1:0] flit_id_out,
   output logic [DATA_W-1:0]    data_out,
   output logic [LENGTH_W-1:0]  length_out,
   output logic                 valid_out,
   output logic                 drop
);

   pkt_state_e             state_q, state_d;
   logic [FLIT_ID_W-1:0]   flit_id_q, flit_id_d;
   logic [DATA_W-1:0]      data_q, data_d;
   logic [LENGTH_W-1:0]    length_q, length_d;
   logic                   valid_q, valid_d;
   logic                   drop_q, drop_d;

   logic [FLIT_ID_W-1:0]   head_id;
   logic [DATA_W-1:0]      head_data;
   logic                   head_is_hdr;
   logic                   head_is_payload;
   logic                   pop_s;
   logic                   discard_s;
   logic                   req_s;

   flit_fifo #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (wr_en),
      .wr_id     (flit_id_in),
      .wr_data   (data_in),
      .rd_en     (pop_s || discard_s),
      .head_id   (head_id),
      .head_data (head_data),
      .full      (full),
      .empty     (empty)
   );

   // Packet FSM: pop/discard decisions, request, next state and output data.
   always_comb begin
      head_is_hdr     = (head_id == FLIT_HEADER);
      head_is_payload = is_payload_flit(head_id);
      pop_s           = 1'b0;
      discard_s       = 1'b0;
      req_s           = 1'b0;
      state_d         = state_q;
      flit_id_d       = flit_id_q;
      data_d          = data_q;
      length_d        = length_q;

      case (state_q)
         IDLE: begin
            req_s     = !empty && head_is_hdr;
            pop_s     = grant && !empty && head_is_hdr;
            // Anything but a HEADER cannot start a packet; flush it without waiting for grant.
            discard_s = !empty && !head_is_hdr;
         end
         IN_PKT: begin
            // Request stays up through body gaps so the output stays allocated.
            req_s     = 1'b1;
            pop_s     = grant && !empty && head_is_payload;
            discard_s = !empty && !head_is_payload;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (pop_s) begin
         flit_id_d = head_id;
         data_d    = head_data;
         if (head_is_hdr) begin
            state_d  = IN_PKT;
            length_d = head_data[LENGTH_W-1:0];
         end else if (head_id == FLIT_TAIL) begin
            state_d = IDLE;
         end else begin
            state_d = state_q;
         end
      end else begin
         flit_id_d = flit_id_q;
         data_d    = data_q;
      end

      valid_d = pop_s;
      drop_d  = discard_s;
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         flit_id_q <= {FLIT_ID_W{1'b0}};
         data_q    <= {DATA_W{1'b0}};
         length_q  <= {LENGTH_W{1'b0}};
         valid_q   <= 1'b0;
         drop_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         flit_id_q <= flit_id_d;
         data_q    <= data_d;
         length_q  <= length_d;
         valid_q   <= valid_d;
         drop_q    <= drop_d;
      end
   end

   assign req         = req_s;
   assign flit_id_out = flit_id_q;
   assign data_out    = data_q;
   assign length_out  = length_q;
   assign valid_out   = valid_q;
   assign drop        = drop_q;

endmodule

// File: tb/tb_input_port_buffer.sv
// ---------------------------------------------------------------------------
// tb_input_port_buffer
// Self-checking bench: a queue-based packet model is checked every cycle,
// a hand-computed vector table covers the basic packet and drop cases, and
// short directed sequences plus a random phase cover the corner cases.
// ---------------------------------------------------------------------------
module tb_input_port_buffer;
   import input_port_buffer_pkg::*;

   localparam int DEPTH = 8;
   localparam int DW    = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          wr_en;
   logic [2:0]    flit_id_in;
   logic [DW-1:0] data_in;
   logic          grant;
   logic          full;
   logic          empty;
   logic          req;
   logic [2:0]    flit_id_out;
   logic [DW-1:0] data_out;
   logic [11:0]   length_out;
   logic          valid_out;
   logic          drop;

   int tests = 0;
   int fails = 0;

   input_port_buffer #(.DEPTH(DEPTH), .DATA_W(DW)) dut (
      .clk         (clk),
      .rst         (rst),
      .wr_en       (wr_en),
      .flit_id_in  (flit_id_in),
      .data_in     (data_in),
      .grant       (grant),
      .full        (full),
      .empty       (empty),
      .req         (req),
      .flit_id_out (flit_id_out),
      .data_out    (data_out),
      .length_out  (length_out),
      .valid_out   (valid_out),
      .drop        (drop)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   typedef struct {
      logic [2:0]    id;
      logic [DW-1:0] data;
   } flit_t;

   flit_t         mq[$];
   bit            m_in_pkt = 1'b0;
   logic [2:0]    m_id     = 3'd0;
   logic [DW-1:0] m_data   = 32'd0;
   logic [11:0]   m_len    = 12'd0;
   logic          m_valid  = 1'b0;
   logic          m_drop   = 1'b0;

   task automatic model_update(input logic r, input logic w, input logic [2:0] id,
                               input logic [DW-1:0] d, input logic g);
      bit    pop;
      bit    disc;
      bit    accept;
      flit_t hd;
      flit_t nf;
      if (r) begin
         mq.delete();
         m_in_pkt = 1'b0;
         m_id = 3'd0; m_data = 32'd0; m_len = 12'd0;
         m_valid = 1'b0; m_drop = 1'b0;
      end else begin
         pop  = 1'b0;
         disc = 1'b0;
         if (mq.size() > 0) begin
            hd = mq[0];
            if (m_in_pkt) begin
               if (hd.id == FLIT_BODY || hd.id == FLIT_TAIL) pop = g;
               else disc = 1'b1;
            end else begin
               if (hd.id == FLIT_HEADER) pop = g;
               else disc = 1'b1;
            end
         end
         accept  = w && (mq.size() < DEPTH);
         m_valid = pop;
         m_drop  = disc;
         if (pop) begin
            m_id   = hd.id;
            m_data = hd.data;
            if (hd.id == FLIT_HEADER) begin
               m_in_pkt = 1'b1;
               m_len    = hd.data[11:0];
            end
            if (hd.id == FLIT_TAIL) m_in_pkt = 1'b0;
         end
         if (pop || disc) void'(mq.pop_front());
         if (accept) begin
            nf.id = id; nf.data = d;
            mq.push_back(nf);
         end
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_model();
      logic e_req;
      e_req = m_in_pkt || (mq.size() > 0 && mq[0].id == FLIT_HEADER);
      check("m_full",  {31'd0, full},      {31'd0, mq.size() == DEPTH});
      check("m_empty", {31'd0, empty},     {31'd0, mq.size() == 0});
      check("m_req",   {31'd0, req},       {31'd0, e_req});
      check("m_valid", {31'd0, valid_out}, {31'd0, m_valid});
      check("m_drop",  {31'd0, drop},      {31'd0, m_drop});
      check("m_id",    {29'd0, flit_id_out}, {29'd0, m_id});
      check("m_data",  data_out,           m_data);
      check("m_len",   {20'd0, length_out}, {20'd0, m_len});
   endtask

   // Drive one cycle of inputs, advance the model on the edge, compare #1 later.
   task automatic step(input logic r, input logic w, input logic [2:0] id,
                       input logic [DW-1:0] d, input logic g);
      rst = r; wr_en = w; flit_id_in = id; data_in = d; grant = g;
      @(posedge clk);
      model_update(r, w, id, d, g);
      #1;
      check_model();
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic          r;
      logic          w;
      logic [2:0]    id;
      logic [DW-1:0] d;
      logic          g;
      logic          e_valid;
      logic          e_drop;
      logic          e_req;
      logic          e_empty;
      logic [2:0]    e_id;
      logic [DW-1:0] e_data;
      logic [11:0]   e_len;
   } vec_t;

   vec_t vt[9];

   int            vcnt;
   bit            seen;
   int unsigned   sel;
   logic [2:0]    rid;
   logic [2:0]    mal[5];

   initial begin
      // HDR(len=5)/BODY/TAIL with grant, then a stray BODY while idle.
      vt[0] = '{1'b1, 1'b0, 3'b000,      32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000,      32'h0,  12'd0};
      vt[1] = '{1'b0, 1'b1, FLIT_HEADER, 32'h5,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000,      32'h0,  12'd0};
      vt[2] = '{1'b0, 1'b1, FLIT_BODY,   32'hB0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, FLIT_HEADER, 32'h5,  12'd5};
      vt[3] = '{1'b0, 1'b1, FLIT_TAIL,   32'h7A, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, FLIT_BODY,   32'hB0, 12'd5};
      vt[4] = '{1'b0, 1'b0, 3'b000,      32'h0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, FLIT_TAIL,   32'h7A, 12'd5};
      vt[5] = '{1'b0, 1'b0, 3'b000,      32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, FLIT_TAIL,   32'h7A, 12'd5};
      vt[6] = '{1'b0, 1'b1, FLIT_BODY,   32'h42, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, FLIT_TAIL,   32'h7A, 12'd5};
      vt[7] = '{1'b0, 1'b0, 3'b000,      32'h0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, FLIT_TAIL,   32'h7A, 12'd5};
      vt[8] = '{1'b0, 1'b0, 3'b000,      32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, FLIT_TAIL,   32'h7A, 12'd5};

      for (int i = 0; i < 9; i++) begin
         step(vt[i].r, vt[i].w, vt[i].id, vt[i].d, vt[i].g);
         check($sformatf("vec%0d_valid", i), {31'd0, valid_out}, {31'd0, vt[i].e_valid});
         check($sformatf("vec%0d_drop", i),  {31'd0, drop},      {31'd0, vt[i].e_drop});
         check($sformatf("vec%0d_req", i),   {31'd0, req},       {31'd0, vt[i].e_req});
         check($sformatf("vec%0d_empty", i), {31'd0, empty},     {31'd0, vt[i].e_empty});
         check($sformatf("vec%0d_id", i),    {29'd0, flit_id_out}, {29'd0, vt[i].e_id});
         check($sformatf("vec%0d_data", i),  data_out,           vt[i].e_data);
         check($sformatf("vec%0d_len", i),   {20'd0, length_out}, {20'd0, vt[i].e_len});
      end

      // Nine writes without grant: ninth is lost.
      step(1'b1, 1'b0, 3'b000, 32'h0, 1'b0);
      step(1'b0, 1'b1, FLIT_HEADER, 32'h3, 1'b0);
      for (int i = 1; i < 8; i++) step(1'b0, 1'b1, FLIT_BODY, 32'(i), 1'b0);
      check("ovf_full_after_8", {31'd0, full}, 32'd1);
      step(1'b0, 1'b1, FLIT_BODY, 32'h99, 1'b0);
      check("ovf_full_after_9", {31'd0, full}, 32'd1);
      vcnt = 0; seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 1'b0, 3'b000, 32'h0, 1'b1);
         if (valid_out === 1'b1) begin
            vcnt++;
            if (data_out === 32'h99) seen = 1'b1;
         end
      end
      check("ovf_pop_count", vcnt, 32'd8);
      check("ovf_9th_lost", {31'd0, seen}, 32'd0);
      step(1'b0, 1'b1, FLIT_TAIL, 32'h55, 1'b1);
      step(1'b0, 1'b0, 3'b000, 32'h0, 1'b1);
      check("ovf_tail_id", {29'd0, flit_id_out}, {29'd0, FLIT_TAIL});
      check("ovf_idle_req", {31'd0, req}, 32'd0);

      // Full FIFO with grant and write together: one pop, write rejected.
      step(1'b1, 1'b0, 3'b000, 32'h0, 1'b0);
      step(1'b0, 1'b1, FLIT_HEADER, 32'h2, 1'b0);
      for (int i = 1; i < 8; i++) step(1'b0, 1'b1, FLIT_BODY, 32'(32'h10 + i), 1'b0);
      check("fwp_full", {31'd0, full}, 32'd1);
      step(1'b0, 1'b1, FLIT_BODY, 32'hEE, 1'b1);
      check("fwp_valid", {31'd0, valid_out}, 32'd1);
      check("fwp_hdr_popped", {29'd0, flit_id_out}, {29'd0, FLIT_HEADER});
      check("fwp_not_full", {31'd0, full}, 32'd0);
      step(1'b0, 1'b1, FLIT_BODY, 32'h77, 1'b0);
      check("fwp_full_again", {31'd0, full}, 32'd1);
      vcnt = 0; seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         step(1'b0, 1'b0, 3'b000, 32'h0, 1'b1);
         if (valid_out === 1'b1) begin
            vcnt++;
            if (data_out === 32'hEE) seen = 1'b1;
         end
      end
      check("fwp_pop_count", vcnt, 32'd8);
      check("fwp_rejected_absent", {31'd0, seen}, 32'd0);
      step(1'b0, 1'b1, FLIT_TAIL, 32'h66, 1'b1);
      step(1'b0, 1'b0, 3'b000, 32'h0, 1'b1);

      // Body gap: request held while the FIFO is empty mid-packet.
      step(1'b1, 1'b0, 3'b000, 32'h0, 1'b0);
      step(1'b0, 1'b1, FLIT_HEADER, 32'h4, 1'b0);
      step(1'b0, 1'b0, 3'b000, 32'h0, 1'b1);
      check("gap_hdr_len", {20'd0, length_out}, 32'd4);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, 3'b000, 32'h0, 1'b1);
         check($sformatf("gap_req%0d", i), {31'd0, req}, 32'd1);
         check($sformatf("gap_empty%0d", i), {31'd0, empty}, 32'd1);
      end
      step(1'b0, 1'b1, FLIT_BODY, 32'hB1, 1'b1);
      check("gap_req_body", {31'd0, req}, 32'd1);
      step(1'b0, 1'b1, FLIT_TAIL, 32'hC1, 1'b1);
      check("gap_body_data", data_out, 32'hB1);
      check("gap_body_id", {29'd0, flit_id_out}, {29'd0, FLIT_BODY});
      step(1'b0, 1'b0, 3'b000, 32'h0, 1'b1);
      check("gap_tail_data", data_out, 32'hC1);
      check("gap_tail_req", {31'd0, req}, 32'd0);

      // Reset mid-packet beats a simultaneous write and grant.
      step(1'b1, 1'b0, 3'b000, 32'h0, 1'b0);
      step(1'b0, 1'b1, FLIT_HEADER, 32'h9, 1'b0);
      step(1'b0, 1'b1, FLIT_BODY, 32'hBB, 1'b1);
      check("mrst_len_before", {20'd0, length_out}, 32'd9);
      step(1'b1, 1'b1, FLIT_TAIL, 32'hCC, 1'b1);
      check("mrst_empty", {31'd0, empty}, 32'd1);
      check("mrst_req", {31'd0, req}, 32'd0);
      check("mrst_len", {20'd0, length_out}, 32'd0);
      step(1'b0, 1'b0, 3'b000, 32'h0, 1'b1);
      check("mrst_still_empty", {31'd0, empty}, 32'd1);
      check("mrst_no_valid", {31'd0, valid_out}, 32'd0);

      // Random traffic against the model, including malformed codes.
      mal[0] = 3'b000; mal[1] = 3'b011; mal[2] = 3'b101; mal[3] = 3'b110; mal[4] = 3'b111;
      for (int i = 0; i < 3000; i++) begin
         sel = $urandom_range(0, 9);
         if (sel < 3)      rid = FLIT_HEADER;
         else if (sel < 6) rid = FLIT_BODY;
         else if (sel < 8) rid = FLIT_TAIL;
         else              rid = mal[$urandom_range(0, 4)];
         step(($urandom_range(0, 299) == 0), ($urandom_range(0, 9) < 6), rid,
              $urandom, ($urandom_range(0, 9) < 7));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
